// File: rtl/hqm_system_mem_rf_pg_ctl.sv
// rtl/hqm_system_mem_rf_pg_ctl.sv - power-gate sequencer for a system-memory register file
// Sequences power enable, settle, de-isolation and reset release, and auto power-down on idle.
module hqm_system_mem_rf_pg_ctl #(
    parameter int SETTLE_CYC = 4,
    parameter int ACK_TMO    = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_req,
    input  logic       acc_req,
    output logic       acc_ready,
    input  logic [7:0] cfg_idle_limit,
    output logic       pg_pwr_enable_b,
    input  logic       pg_pwr_ack_b,
    output logic       pg_isol_en,
    output logic       pg_ip_reset_b,
    input  logic       pg_err_clr,
    output logic       pg_err,
    output logic [2:0] pg_state
);

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_PWRUP  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_UNISO  = 3'd3;
    localparam logic [2:0] ST_ON     = 3'd4;
    localparam logic [2:0] ST_ISO    = 3'd5;
    localparam logic [2:0] ST_PWRDN  = 3'd6;

    localparam logic [7:0] TMO_LAST    = 8'(ACK_TMO - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] idle_q, idle_d;
    logic       err_q, err_d;
    logic       err_set;
    logic       any_req;

    logic       enable_b_q, enable_b_d;
    logic       isol_q, isol_d;
    logic       reset_b_q, reset_b_d;
    logic       ready_q, ready_d;

    assign any_req = pwr_req | acc_req;

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        idle_d  = 8'd0;
        case (state_q)
            ST_OFF: begin
                if (any_req) state_d = ST_PWRUP;
            end
            ST_PWRUP: begin
                if (!pg_pwr_ack_b) begin
                    state_d = ST_SETTLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_OFF;
                    err_set = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = ST_UNISO;
            end
            ST_UNISO: state_d = ST_ON;
            ST_ON: begin
                if (!any_req) begin
                    if (idle_q == cfg_idle_limit) begin
                        state_d = ST_ISO;
                    end else if (idle_q != 8'hff) begin
                        idle_d = idle_q + 8'd1;
                    end else begin
                        idle_d = idle_q;
                    end
                end
            end
            ST_ISO: state_d = ST_PWRDN;
            ST_PWRDN: begin
                if (pg_pwr_ack_b) begin
                    state_d = ST_OFF;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_OFF;
                    err_set = 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Both dwell counters restart on every state entry.
        if (state_d != state_q) begin
            tmo_d = 8'd0;
        end else if (state_q == ST_PWRUP || state_q == ST_PWRDN) begin
            tmo_d = tmo_q + 8'd1;
        end else begin
            tmo_d = 8'd0;
        end
        settle_d = (state_q == ST_SETTLE && state_d == ST_SETTLE) ? settle_q + 4'd1 : 4'd0;

        err_d = err_set ? 1'b1 : (pg_err_clr ? 1'b0 : err_q);
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        enable_b_d = 1'b1;
        isol_d     = 1'b1;
        reset_b_d  = 1'b0;
        ready_d    = 1'b0;
        case (state_d)
            ST_PWRUP, ST_SETTLE: enable_b_d = 1'b0;
            ST_UNISO, ST_ISO: begin
                enable_b_d = 1'b0;
                reset_b_d  = 1'b1;
            end
            ST_ON: begin
                enable_b_d = 1'b0;
                isol_d     = 1'b0;
                reset_b_d  = 1'b1;
                ready_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OFF;
            tmo_q      <= 8'd0;
            settle_q   <= 4'd0;
            idle_q     <= 8'd0;
            err_q      <= 1'b0;
            enable_b_q <= 1'b1;
            isol_q     <= 1'b1;
            reset_b_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            settle_q   <= settle_d;
            idle_q     <= idle_d;
            err_q      <= err_d;
            enable_b_q <= enable_b_d;
            isol_q     <= isol_d;
            reset_b_q  <= reset_b_d;
            ready_q    <= ready_d;
        end
    end

    assign pg_state        = state_q;
    assign pg_err          = err_q;
    assign pg_pwr_enable_b = enable_b_q;
    assign pg_isol_en      = isol_q;
    assign pg_ip_reset_b   = reset_b_q;
    assign acc_ready       = ready_q;

endmodule

// File: tb/tb_hqm_system_mem_rf_pg_ctl.sv
// tb/tb_hqm_system_mem_rf_pg_ctl.sv - randomized model-checked bench for the RF power-gate sequencer
module tb_hqm_system_mem_rf_pg_ctl;

    localparam int SETTLE_CYC = 4;
    localparam int ACK_TMO    = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_req, acc_req, err_clr;
    logic [7:0] limit;
    logic       acc_ready, en_b, ack_b, isol, rstb, pg_err;
    logic [2:0] pg_state;

    int checks = 0;
    int errors = 0;

    int m_st, m_dwell, m_idle;
    bit m_err;

    int         ack_dly;
    bit         ack_stuck, ack_stuck_val;
    logic [3:0] pipe = 4'hf;
    logic [4:0] tap;

    always #5 clk = ~clk;

    always @(posedge clk) pipe <= {pipe[2:0], en_b};
    assign tap   = {pipe, en_b};
    assign ack_b = ack_stuck ? ack_stuck_val : tap[ack_dly];

    hqm_system_mem_rf_pg_ctl #(.SETTLE_CYC(SETTLE_CYC), .ACK_TMO(ACK_TMO)) dut (
        .clk(clk), .rst(rst), .pwr_req(pwr_req), .acc_req(acc_req), .acc_ready(acc_ready),
        .cfg_idle_limit(limit), .pg_pwr_enable_b(en_b), .pg_pwr_ack_b(ack_b),
        .pg_isol_en(isol), .pg_ip_reset_b(rstb), .pg_err_clr(err_clr), .pg_err(pg_err),
        .pg_state(pg_state)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // {enable_b, isol_en, ip_reset_b, acc_ready} for each state
    function automatic logic [3:0] exp_out(input int st);
        case (st)
            1, 2:    return 4'b0100;
            3, 5:    return 4'b0110;
            4:       return 4'b0011;
            default: return 4'b1100;
        endcase
    endfunction

    task automatic compare();
        chk("state", pg_state, m_st);
        chk("outputs", {en_b, isol, rstb, acc_ready}, exp_out(m_st));
        chk("err", pg_err, m_err);
    endtask

    task automatic model_reset();
        m_st = 0; m_dwell = 0; m_idle = 0; m_err = 0;
    endtask

    task automatic model_step();
        int nst;
        bit set;
        bit req;
        nst = m_st;
        set = 0;
        req = pwr_req || acc_req;
        case (m_st)
            0: if (req) nst = 1;
            1: if (!ack_b) nst = 2;
               else if (m_dwell + 1 >= ACK_TMO) begin nst = 0; set = 1; end
            2: if (m_dwell + 1 == SETTLE_CYC) nst = 3;
            3: nst = 4;
            4: if (req) m_idle = 0;
               else if (m_idle == int'(limit)) nst = 5;
               else m_idle = (m_idle < 255) ? m_idle + 1 : 255;
            5: nst = 6;
            6: if (ack_b) nst = 0;
               else if (m_dwell + 1 >= ACK_TMO) begin nst = 0; set = 1; end
            default: nst = 0;
        endcase
        if (nst != 4) m_idle = 0;
        m_dwell = (nst == m_st) ? m_dwell + 1 : 0;
        m_err = set ? 1'b1 : (err_clr ? 1'b0 : m_err);
        m_st = nst;
    endtask

    task automatic tick();
        #1;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        @(negedge clk);
        compare();
        rst = 1'b0;
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (int'(pg_state) != target && n < budget) begin
            tick();
            n++;
        end
        chk(name, pg_state, target);
    endtask

    initial begin
        int exp_seq[7];
        int n;
        bit busy;
        exp_seq = '{1, 2, 2, 2, 2, 3, 4};
        rst = 1'b1; pwr_req = 0; acc_req = 0; err_clr = 0; limit = 8'd3;
        ack_dly = 0; ack_stuck = 0; ack_stuck_val = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("reset_state", pg_state, 0);
        chk("reset_outputs", {en_b, isol, rstb, acc_ready, pg_err}, 5'b11000);

        // power-up latency with ack in the first PWRUP cycle
        acc_req = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("pwrup_seq", pg_state, exp_seq[i]);
        end
        chk("pwrup_ready", acc_ready, 1);

        // idle power-down with limit 3
        acc_req = 0;
        n = 0;
        do begin tick(); n++; end while (pg_state == 3'd4 && n < 20);
        chk("idle_on_cycles", n, 4);
        chk("iso_isol_before_enable", {isol, en_b}, 2'b10);
        tick();
        chk("pwrdn_state", pg_state, 6);
        tick();
        chk("pwrdn_off", pg_state, 0);

        // idle interrupted at count 2 clears the counter
        acc_req = 1;
        wait_state(4, 20, "reach_on");
        acc_req = 0;
        tick(); tick();
        acc_req = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("interrupt_stays_on", pg_state, 4);
        end
        acc_req = 0;
        n = 0;
        do begin tick(); n++; end while (pg_state == 3'd4 && n < 20);
        chk("idle_after_interrupt", n, 4);
        wait_state(0, 10, "back_off");

        // power-up ack timeout, then clear
        ack_stuck = 1; ack_stuck_val = 1;
        acc_req = 1;
        tick();
        n = 0;
        while (pg_state == 3'd1 && n < 300) begin
            n++;
            tick();
        end
        chk("tmo_cycles", n, ACK_TMO);
        chk("tmo_err", pg_err, 1);
        chk("tmo_off", pg_state, 0);
        acc_req = 0; ack_stuck = 0; err_clr = 1;
        tick();
        chk("err_cleared", pg_err, 0);
        err_clr = 0;

        // request during PWRDN completes power-down first
        ack_dly = 3;
        pwr_req = 1;
        wait_state(4, 30, "dly_reach_on");
        pwr_req = 0; limit = 8'd0;
        wait_state(6, 10, "reach_pwrdn");
        acc_req = 1;
        wait_state(0, 10, "pwrdn_completes");
        tick();
        chk("pwrup_after_pwrdn", pg_state, 1);

        // asynchronous reset in SETTLE
        ack_dly = 0;
        wait_state(2, 20, "reach_settle");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", pg_state, 0);
        chk("async_rst_outputs", {en_b, isol, rstb, acc_ready}, 4'b1100);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare();
        rst = 1'b0;
        acc_req = 0;

        // randomized traffic
        busy = 1;
        limit = 8'd2;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 60 == 0) busy = ($urandom % 2) == 1;
            pwr_req = busy ? ($urandom % 4 != 0) : ($urandom % 20 == 0);
            acc_req = busy ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
            err_clr = ($urandom % 8 == 0);
            if ($urandom % 64 == 0) limit = 8'($urandom % 8);
            if ($urandom % 50 == 0) ack_dly = $urandom % 4;
            if ($urandom % 150 == 0) begin
                ack_stuck = !ack_stuck;
                ack_stuck_val = $urandom % 2;
            end
            if ($urandom % 700 == 0) do_reset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hqm_system_mem_rf_pg_ctl.md
HQM_SYSTEM_MEM_RF_PG_CTL -- requirements
Module: hqm_system_mem_rf_pg_ctl

Interface
REQ-001 Parameter SETTLE_CYC, default 4, cycles from power ack to RF reset release (legal 1..15).
REQ-002 Parameter ACK_TMO, default 63, max cycles waiting for power ack before error (legal 2..255).
REQ-003 clk  in  1  single clock for all state.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 pwr_req  in  1  level: keep RF powered.
REQ-006 acc_req  in  1  level: requester wants an RF access.
REQ-007 acc_ready  out  1  access permitted this cycle (RF on, de-isolated).
REQ-008 cfg_idle_limit  in  8  consecutive idle cycles in ON before auto power-down.
REQ-009 pg_pwr_enable_b  out  1  to RF pwr_enable_b_in; 1 = power off.
REQ-010 pg_pwr_ack_b  in  1  from RF pwr_enable_b_out; follows pg_pwr_enable_b when power has settled.
REQ-011 pg_isol_en  out  1  to RF pgcb_isol_en; 1 = isolated.
REQ-012 pg_ip_reset_b  out  1  to RF ip_reset_b; 0 = RF held in reset.
REQ-013 pg_err_clr  in  1  clears pg_err.
REQ-014 pg_err  out  1  sticky ack-timeout flag.
REQ-015 pg_state  out  3  current state encoding.

Function
REQ-016 States/encoding SHALL be OFF=0, PWRUP=1, SETTLE=2, UNISO=3, ON=4, ISO=5, PWRDN=6; 7 unreachable, recovers to OFF next cycle.
REQ-017 All outputs SHALL be registered functions of state: OFF {enable_b=1,isol=1,rst_b=0}; PWRUP/SETTLE {0,1,0}; UNISO {0,1,1}; ON {0,0,1}; ISO {0,1,1}; PWRDN {1,1,0}.
REQ-018 acc_ready SHALL be 1 only in ON.
REQ-019 OFF -> PWRUP when pwr_req|acc_req sampled 1.
REQ-020 PWRUP -> SETTLE when pg_pwr_ack_b sampled 0; ack wins over timeout in same cycle.
REQ-021 PWRUP timeout: after ACK_TMO cycles in PWRUP without ack, set pg_err and go to OFF.
REQ-022 SETTLE SHALL last exactly SETTLE_CYC cycles, then UNISO.
REQ-023 UNISO SHALL last exactly 1 cycle, then ON.
REQ-024 Idle counter: 8-bit saturating, counts ON cycles with pwr_req=0 and acc_req=0; cleared by any request or outside ON.
REQ-025 ON -> ISO when both requests 0 and idle counter equals cfg_idle_limit (limit 0: first idle cycle).
REQ-026 ISO SHALL last exactly 1 cycle, then PWRDN.
REQ-027 PWRDN -> OFF when pg_pwr_ack_b sampled 1; after ACK_TMO cycles without ack, set pg_err and go to OFF.
REQ-028 Requests arriving in ISO or PWRDN SHALL NOT abort power-down; they are served from OFF.
REQ-029 Timeout counter SHALL clear on every state entry and count only in PWRUP/PWRDN.
REQ-030 pg_err set and pg_err_clr in same cycle: set wins.
REQ-031 Latency: acc_req rising in OFF with ack during first PWRUP cycle SHALL give acc_ready 3+SETTLE_CYC cycles later (7 at default).
REQ-032 cfg_idle_limit changes SHALL take effect the next cycle, compared against current count.

Reset
REQ-033 While rst=1: state OFF, pg_pwr_enable_b=1, pg_isol_en=1, pg_ip_reset_b=0, acc_ready=0, pg_err=0, pg_state=0, counters 0.
REQ-034 Reset mid-sequence (any state) SHALL force OFF outputs asynchronously, with no intermediate ISO/PWRDN.
REQ-035 After rst deassert, first transition SHALL occur no earlier than the first clk edge.

Verification
REQ-036 Power-up: acc_req=1 at cycle 0, ack model 1-cycle echo -> pg_state 1,2,2,2,2,3,4; acc_ready=1 at cycle 7.
REQ-037 Idle power-down: cfg_idle_limit=3, drop requests in ON -> ISO after 3 idle cycles, then PWRDN, OFF when ack_b=1; isol rises before enable_b.
REQ-038 Ack timeout: hold pg_pwr_ack_b=1 in PWRUP -> after 63 cycles pg_err=1, state OFF; pg_err_clr pulse -> pg_err=0.
REQ-039 Request during PWRDN: acc_req=1 in PWRDN -> completes OFF, then PWRUP next cycle.
REQ-040 Async reset in SETTLE -> OFF outputs same cycle without clk edge; pg_state=0.
REQ-041 Idle interrupt: requests return at idle count 2 of limit 3 -> counter clears, state stays ON.
